// File: rtl/kmuldiv_pkg.sv
// rtl/kmuldiv_pkg.sv - shared constants and types for the kmuldiv multiplier/divider
package kmuldiv_pkg;

    localparam logic [2:0] ADDR_A_LO = 3'd0;
    localparam logic [2:0] ADDR_A_HI = 3'd1;
    localparam logic [2:0] ADDR_B_LO = 3'd2;
    localparam logic [2:0] ADDR_B_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_AUTO  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DZ   = 1;
    localparam int STAT_AUTO = 2;
    localparam int STAT_MODE = 3;
    localparam int STAT_DONE = 7;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/kmuldiv_core.sv
// rtl/kmuldiv_core.sv - iterative shift-add multiplier / restoring divider, one step per clock
// Divider path present only when KMULDIV_DIV_EN is defined.
module kmuldiv_core
    import kmuldiv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef KMULDIV_DIV_EN
    input  mode_t          mode,
    output logic           dz,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state, state_next;
    logic [2*W-1:0] p, p_next;
    logic [W-1:0]   m;
    logic [W:0]     sum;
    logic [CW-1:0]  count;
    logic           finish;

`ifdef KMULDIV_DIV_EN
    logic           div_r, dz_r;
    logic [W:0]     r_sh, diff;
`endif

    // p holds {accumulator, multiplier} for mul and {remainder, quotient} for div
    always_comb begin
        sum    = {1'b0, p[2*W-1:W]} + {1'b0, m};
        p_next = p[0] ? {sum, p[W-1:1]} : {1'b0, p[2*W-1:1]};
`ifdef KMULDIV_DIV_EN
        r_sh = {p[2*W-1:W], p[W-1]};
        diff = r_sh - {1'b0, m};
        if (div_r) begin
            p_next = diff[W] ? {r_sh[W-1:0], p[W-2:0], 1'b0}
                             : {diff[W-1:0], p[W-2:0], 1'b1};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef KMULDIV_DIV_EN
        finish = (count == LAST) || dz_r;
        result = dz_r ? p : p_next;
        dz     = dz_r;
`else
        finish = (count == LAST);
        result = p_next;
`endif
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (finish) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            m     <= '0;
            count <= '0;
`ifdef KMULDIV_DIV_EN
            div_r <= 1'b0;
            dz_r  <= 1'b0;
`endif
        end else if (state == ST_IDLE) begin
            if (start) begin
                count <= '0;
                m     <= a;
                p     <= {{W{1'b0}}, b};
`ifdef KMULDIV_DIV_EN
                div_r <= (mode == MODE_DIV);
                dz_r  <= 1'b0;
                if (mode == MODE_DIV) begin
                    m <= b;
                    // zero divisor: result is preloaded and the single RUN cycle commits it
                    if (b == '0) begin
                        dz_r <= 1'b1;
                        p    <= {a, {W{1'b1}}};
                    end else begin
                        p    <= {{W{1'b0}}, a};
                    end
                end
`endif
            end
        end else if (!finish) begin
            p     <= p_next;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/kmuldiv_seq.sv
// rtl/kmuldiv_seq.sv - bus-mapped wrapper: register decode, operand/CTRL/result registers, read mux
// Divider, MODE and DZ exist only when KMULDIV_DIV_EN is defined.
module kmuldiv_seq
    import kmuldiv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic [2:0] AB,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       BUSY
);

    localparam logic [2:0] ADDR_B_TOP = (W == 16) ? ADDR_B_HI : ADDR_B_LO;

    logic           wr_d, wr_acc, wr_open, start;
    logic [W-1:0]   a_reg, b_reg, a_next, b_next;
    logic [2*W-1:0] r_reg, core_result;
    logic [31:0]    r_wide;
    logic           auto_reg, done_reg, core_done, mode_bit, dz_bit;
    logic [7:0]     status;

`ifdef KMULDIV_DIV_EN
    mode_t          mode_reg, mode_next;
    logic           dz_reg, core_dz;
`endif

    // one accepted write per WR pulse: falling WR seen against the registered copy
    assign wr_acc  = !CS && !WR && wr_d;
    assign wr_open = wr_acc && !BUSY;
    assign start   = wr_open && (((AB == ADDR_CTRL) && DIN[CTRL_START]) ||
                                 ((AB == ADDR_B_TOP) && auto_reg));

    // next operand values feed the core directly so an auto-start sees the byte being written
    always_comb begin
        a_next = a_reg;
        b_next = b_reg;
        if (wr_open) begin
            case (AB)
                ADDR_A_LO: a_next[7:0] = DIN;
                ADDR_A_HI: if (W == 16) a_next[W-1 -: 8] = DIN;
                ADDR_B_LO: b_next[7:0] = DIN;
                ADDR_B_HI: if (W == 16) b_next[W-1 -: 8] = DIN;
                default: ;
            endcase
        end
    end

`ifdef KMULDIV_DIV_EN
    always_comb begin
        mode_next = mode_reg;
        if (wr_open && (AB == ADDR_CTRL)) mode_next = mode_t'(DIN[CTRL_MODE]);
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            mode_reg <= MODE_MUL;
            dz_reg   <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            if (start)          dz_reg <= 1'b0;
            else if (core_done) dz_reg <= core_dz;
        end
    end

    assign mode_bit = (mode_reg == MODE_DIV);
    assign dz_bit   = dz_reg;
`else
    assign mode_bit = 1'b0;
    assign dz_bit   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            wr_d     <= 1'b1;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            auto_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            wr_d  <= WR;
            a_reg <= a_next;
            b_reg <= b_next;
            // AUTO stays writable while busy
            if (wr_acc && (AB == ADDR_CTRL)) auto_reg <= DIN[CTRL_AUTO];
            if (start) begin
                done_reg <= 1'b0;
            end else if (core_done) begin
                done_reg <= 1'b1;
                r_reg    <= core_result;
            end
        end
    end

    kmuldiv_core #(.W(W)) u_core (
        .clk    (CLK),
        .rst_n  (RES),
        .start  (start),
        .a      (a_next),
        .b      (b_next),
`ifdef KMULDIV_DIV_EN
        .mode   (mode_next),
        .dz     (core_dz),
`endif
        .busy   (BUSY),
        .done   (core_done),
        .result (core_result)
    );

    assign r_wide = 32'(r_reg);

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = BUSY;
        status[STAT_DZ]   = dz_bit;
        status[STAT_AUTO] = auto_reg;
        status[STAT_MODE] = mode_bit;
        status[STAT_DONE] = done_reg;
    end

    always_comb begin
        DOUT = '0;
        case (AB)
            ADDR_A_LO: DOUT = r_wide[7:0];
            ADDR_A_HI: DOUT = r_wide[15:8];
            ADDR_B_LO: DOUT = r_wide[23:16];
            ADDR_B_HI: DOUT = r_wide[31:24];
            ADDR_CTRL: DOUT = status;
            default:   DOUT = '0;
        endcase
    end

    assign DOE = !CS && !RD;

endmodule
